// File: rtl/scale_demux.sv
// -----------------------------------------------------------------------------
// scale_demux
//   Routes one valid/ready input stream to one of two output channels (A or B)
//   chosen per word by sel_a. Each channel has its own 2-entry in-order buffer
//   and a wrapping counter of words delivered to its consumer.
//
// Ports
//   clk        rising-edge clock
//   rst_       asynchronous active-low reset
//   in_data    word offered for routing
//   in_valid   in_data is valid this cycle
//   sel_a      1 -> channel A, 0 -> channel B (sampled with in_data)
//   in_ready   selected channel has room (depends on occupancy and sel_a only)
//   out_a/b    head-of-buffer word for each channel (0 when empty)
//   a/b_valid  channel holds at least one word
//   a/b_ready  channel consumer accepts the head word
//   a/b_xfers  count of words delivered on each channel, wraps
// -----------------------------------------------------------------------------
module scale_demux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sel_a,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_xfers,
  output logic [CNT_W-1:0] b_xfers
);

  // Channel index 0 is A, index 1 is B.
  logic [1:0]            ch_sel;
  logic [1:0]            ch_ready;
  logic [1:0][1:0]       ch_count;
  logic [1:0][WIDTH-1:0] ch_data;
  logic [1:0][CNT_W-1:0] ch_xfers;
  logic                  push_ok;

  assign ch_sel   = {~sel_a, sel_a};
  assign ch_ready = {b_ready, a_ready};

  // Room is judged on registered occupancy only: a full channel stays
  // not-ready even if its consumer pops in the same cycle.
  assign in_ready = sel_a ? (ch_count[0] < 2'd2) : (ch_count[1] < 2'd2);
  assign push_ok  = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [WIDTH-1:0] slot0_reg;   // head of buffer
      logic [WIDTH-1:0] slot1_reg;   // second-oldest word
      logic [1:0]       count_reg;
      logic [CNT_W-1:0] xfers_reg;
      logic             push;
      logic             pop;

      assign push = push_ok && ch_sel[gi];
      assign pop  = (count_reg != 2'd0) && ch_ready[gi];

      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          slot0_reg <= '0;
          slot1_reg <= '0;
          count_reg <= 2'd0;
          xfers_reg <= '0;
        end else begin
          if (push && pop) begin
            // Only reachable at count 1 (a full channel refuses pushes),
            // so the new word simply replaces the departing head.
            slot0_reg <= in_data;
          end else if (push) begin
            if (count_reg == 2'd0) begin
              slot0_reg <= in_data;
            end else begin
              slot1_reg <= in_data;
            end
            count_reg <= count_reg + 2'd1;
          end else if (pop) begin
            slot0_reg <= slot1_reg;
            count_reg <= count_reg - 2'd1;
          end

          if (pop) begin
            xfers_reg <= xfers_reg + 1'b1;
          end
        end
      end

      assign ch_count[gi] = count_reg;
      // Empty channels present zero rather than stale storage.
      assign ch_data[gi]  = (count_reg != 2'd0) ? slot0_reg : '0;
      assign ch_xfers[gi] = xfers_reg;
    end
  endgenerate

  assign out_a   = ch_data[0];
  assign out_b   = ch_data[1];
  assign a_valid = (ch_count[0] != 2'd0);
  assign b_valid = (ch_count[1] != 2'd0);
  assign a_xfers = ch_xfers[0];
  assign b_xfers = ch_xfers[1];

endmodule

// File: tb/tb_scale_demux.sv
module tb_scale_demux;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             sel_a;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] out_b;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_xfers;
  logic [CNT_W-1:0] b_xfers;

  int checks_cnt;
  int errors_cnt;

  scale_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sel_a    (sel_a),
    .in_ready (in_ready),
    .out_a    (out_a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .out_b    (out_b),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_xfers  (a_xfers),
    .b_xfers  (b_xfers)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sel_a    = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    tick();
    rst_ = 1'b1;
  endtask

  task automatic push(input logic to_a, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    sel_a    = to_a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [CNT_W-1:0] xf_exp [5];

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sel_a    = 1'b1;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // Reset state
    #2;
    check_val("rst_a_valid", a_valid, 0);
    check_val("rst_b_valid", b_valid, 0);
    check_val("rst_out_a", out_a, 0);
    check_val("rst_out_b", out_b, 0);
    check_val("rst_a_xfers", a_xfers, 0);
    check_val("rst_b_xfers", b_xfers, 0);
    check_val("rst_in_ready_a", in_ready, 1);
    sel_a = 1'b0; #1;
    check_val("rst_in_ready_b", in_ready, 1);
    tick();
    rst_ = 1'b1;
    check_val("post_rst_in_ready", in_ready, 1);

    // Single push, 1-cycle latency
    in_valid = 1'b1; sel_a = 1'b1; in_data = 8'h5A; #1;
    check_val("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_data = 8'hFF; sel_a = 1'b0;
    check_val("t1_a_valid", a_valid, 1);
    check_val("t1_out_a", out_a, 8'h5A);
    check_val("t1_b_valid", b_valid, 0);
    check_val("t1_a_xfers", a_xfers, 0);
    tick();
    check_val("t1_hold_out_a", out_a, 8'h5A);

    // Fill A, backpressure, then drain in order
    do_reset();
    push(1'b1, 8'h11);
    push(1'b1, 8'h22);
    sel_a = 1'b1; #1;
    check_val("t2_in_ready_full", in_ready, 0);
    sel_a = 1'b0; #1;
    check_val("t2_in_ready_b", in_ready, 1);
    sel_a = 1'b1; a_ready = 1'b1; in_valid = 1'b1; in_data = 8'h99; #1;
    check_val("t2_no_passthru", in_ready, 0);
    check_val("t2_head0", out_a, 8'h11);
    tick();
    in_valid = 1'b0;
    check_val("t2_head1", out_a, 8'h22);
    tick();
    a_ready = 1'b0;
    check_val("t2_a_valid_empty", a_valid, 0);
    check_val("t2_out_a_empty", out_a, 0);
    check_val("t2_a_xfers", a_xfers, 2);

    // Simultaneous push and pop at count 1
    do_reset();
    push(1'b1, 8'h44);
    in_valid = 1'b1; sel_a = 1'b1; in_data = 8'h33; a_ready = 1'b1; #1;
    check_val("t3_head_before", out_a, 8'h44);
    tick();
    in_valid = 1'b0; a_ready = 1'b0;
    check_val("t3_a_valid", a_valid, 1);
    check_val("t3_out_a", out_a, 8'h33);
    check_val("t3_in_ready", in_ready, 1);
    check_val("t3_a_xfers", a_xfers, 1);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check_val("t3_drained", a_valid, 0);

    // Alternating routing with both consumers ready
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      sel_a    = (i % 2 == 0);
      in_data  = WIDTH'(i + 1);
      tick();
      if (i % 2 == 0) begin
        check_val($sformatf("t4_a_data%0d", i), out_a, i + 1);
        check_val($sformatf("t4_b_idle%0d", i), b_valid, 0);
      end else begin
        check_val($sformatf("t4_b_data%0d", i), out_b, i + 1);
        check_val($sformatf("t4_a_idle%0d", i), a_valid, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    check_val("t4_a_xfers", a_xfers, 2);
    check_val("t4_b_xfers", b_xfers, 2);
    check_val("t4_b_empty", b_valid, 0);

    // Counter wrap on channel B (CNT_W=2)
    do_reset();
    xf_exp[0] = 2'd1; xf_exp[1] = 2'd2; xf_exp[2] = 2'd3; xf_exp[3] = 2'd0; xf_exp[4] = 2'd1;
    b_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 8'hB0 + 8'(i));
      check_val($sformatf("t5_out_b%0d", i), out_b, 8'hB0 + i);
      tick();
      check_val($sformatf("t5_b_xfers%0d", i), b_xfers, xf_exp[i]);
    end
    b_ready = 1'b0;

    // Async reset with both channels full, then push into emptied channel
    do_reset();
    push(1'b0, 8'h77);
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    push(1'b1, 8'hA1);
    push(1'b1, 8'hA2);
    push(1'b0, 8'hB1);
    push(1'b0, 8'hB2);
    sel_a = 1'b1; #1;
    check_val("t6_full_a_ready", in_ready, 0);
    check_val("t6_b_xfers_pre", b_xfers, 1);
    #2;
    rst_ = 1'b0;
    #1;
    check_val("t6_async_a_valid", a_valid, 0);
    check_val("t6_async_b_valid", b_valid, 0);
    check_val("t6_async_out_a", out_a, 0);
    check_val("t6_async_out_b", out_b, 0);
    check_val("t6_async_b_xfers", b_xfers, 0);
    check_val("t6_async_in_ready_a", in_ready, 1);
    sel_a = 1'b0; #1;
    check_val("t6_async_in_ready_b", in_ready, 1);
    tick();
    rst_ = 1'b1;
    push(1'b1, 8'hC3);
    check_val("t6_after_out_a", out_a, 8'hC3);
    check_val("t6_after_a_valid", a_valid, 1);
    check_val("t6_after_b_valid", b_valid, 0);
    check_val("t6_after_a_xfers", a_xfers, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/scale_demux.md
SCALE_DEMUX -- requirements
Module: scale_demux

Interface
REQ-001 Parameter WIDTH, default 1: data width of the input and both output channels.
REQ-002 Parameter CNT_W, default 8: width of the per-channel transfer counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  WIDTH  data word offered for routing.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 sel_a  input  1  route select: 1 -> channel A, 0 -> channel B; sampled with in_data.
REQ-008 in_ready  output  1  the selected channel can accept a word this cycle.
REQ-009 out_a  output  WIDTH  channel A head-of-buffer data.
REQ-010 a_valid  output  1  out_a holds a valid word.
REQ-011 a_ready  input  1  channel A consumer accepts out_a.
REQ-012 out_b  output  WIDTH  channel B head-of-buffer data.
REQ-013 b_valid  output  1  out_b holds a valid word.
REQ-014 b_ready  input  1  channel B consumer accepts out_b.
REQ-015 a_xfers  output  CNT_W  count of words delivered on channel A.
REQ-016 b_xfers  output  CNT_W  count of words delivered on channel B.

Function
REQ-017 Each channel SHALL own an independent 2-entry in-order buffer with an occupancy count of 0..2.
REQ-018 Input push SHALL occur when in_valid && in_ready, writing in_data into the buffer selected by sel_a in that same cycle.
REQ-019 in_ready SHALL equal (count_A < 2) when sel_a=1 and (count_B < 2) when sel_a=0: combinational from registered occupancy and sel_a only, with no dependency on a_ready or b_ready.
REQ-020 A channel pop SHALL occur when <ch>_valid && <ch>_ready; the word SHALL be removed from the head of the buffer.
REQ-021 <ch>_valid SHALL be 1 exactly when that channel's count is nonzero; out_<ch> SHALL present the oldest buffered word, and 0 when the count is 0.
REQ-022 Latency SHALL be exactly 1 cycle: a word pushed into an empty channel at edge N SHALL appear on out_<ch> with <ch>_valid=1 after edge N.
REQ-023 Outputs SHALL come from registered storage; there SHALL be no combinational path from in_data or in_valid to any out_<ch> or <ch>_valid.
REQ-024 Simultaneous push and pop on the same channel SHALL leave its count unchanged and preserve FIFO order.
REQ-025 With a full channel (count=2) and a pop in the same cycle, in_ready SHALL remain 0 for that cycle; no pass-through.
REQ-026 A push to one channel and a pop from the other in the same cycle SHALL both complete independently.
REQ-027 Words SHALL never be dropped, duplicated or reordered within a channel; ordering between channels is not defined.
REQ-028 <ch>_xfers SHALL increment by 1 on each pop of that channel and wrap from 2^CNT_W-1 to 0.
REQ-029 Behaviour with in_valid=0 SHALL be independent of sel_a and in_data.

Reset
REQ-030 While rst_=0, asynchronously: both counts = 0; a_valid = b_valid = 0; out_a = out_b = 0; a_xfers = b_xfers = 0.
REQ-031 in_ready SHALL read 1 during and immediately after reset, since both channels are empty.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words; the first push after release SHALL behave as a push into an empty channel.

Verification
REQ-033 WIDTH=8: push 0x5A with sel_a=1 and a_ready=0 -> next cycle a_valid=1, out_a=0x5A, b_valid=0, a_xfers=0.
REQ-034 a_ready=0: push 0x11, then 0x22 to A -> in_ready=0 while sel_a=1, and in_ready=1 while sel_a=0; raise a_ready -> 0x11 then 0x22 delivered, a_xfers=2.
REQ-035 Channel A at count=1 with a simultaneous push 0x33 and pop -> count stays 1 and out_a=0x33 next cycle.
REQ-036 Alternating sel_a pushes of 0x01..0x04 with both ready=1 -> A delivers 0x01, 0x03; B delivers 0x02, 0x04; each valid 1 cycle after its push.
REQ-037 CNT_W=2: five pops on channel B -> b_xfers sequence 1, 2, 3, 0, 1.
REQ-038 Assert rst_=0 with both channels full -> outputs, counts and counters 0 immediately with no clock edge, and in_ready=1.
